button_shaper: RTL and testbench

BUTTON_SHAPER -- requirements
Module: button_shaper

---
 rtl/button_shaper.sv | 39 +++
 tb/tb_button_shaper.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/button_shaper.sv
// Pushbutton press shaper: turns an active-low, Clk-synchronous button level into
// a single one-cycle active-high pulse per press (Moore FSM, output from state only).
module button_shaper (
    input  logic Clk,
    input  logic Rst,
    input  logic B_in,
    output logic B_out
);

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        PULSE = 2'b01,
        WAIT  = 2'b10
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // The fourth encoding (2'b11) falls to the default arm and recovers to INIT.
    always_comb begin
        state_d = INIT;
        unique case (state_q)
            INIT:    state_d = B_in ? INIT : PULSE;
            PULSE:   state_d = WAIT;
            WAIT:    state_d = B_in ? INIT : WAIT;
            default: state_d = INIT;
        endcase
    end

    assign B_out = (state_q == PULSE);

endmodule

// File: tb/tb_button_shaper.sv
// Directed table-driven bench for button_shaper, plus hand-written sequences for
// held presses, alternating input and the registered-output property.
module tb_button_shaper;

    logic Clk;
    logic Rst;
    logic B_in;
    logic B_out;

    int unsigned total;
    int unsigned bad;

    button_shaper dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .B_in (B_in),
        .B_out(B_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic rst;
        logic b;
        logic exp;
    } vec_t;

    vec_t        vecs[64];
    int unsigned nvec;

    task automatic add(input logic rst, input logic b, input logic exp);
        vecs[nvec] = '{rst: rst, b: b, exp: exp};
        nvec++;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: B_out=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, let one rising edge happen, sample 1 time unit later.
    task automatic step(input logic rst, input logic b, input logic exp, input string name);
        @(negedge Clk);
        Rst  = rst;
        B_in = b;
        @(posedge Clk);
        #1;
        check(name, B_out, exp);
    endtask

    initial begin
        int unsigned pulses;
        total = 0;
        bad   = 0;
        nvec  = 0;
        Rst   = 1'b0;
        B_in  = 1'b1;

        // reset
        add(1'b0, 1'b1, 1'b0);
        // single press held 6 edges
        add(1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0);
        // release then re-press for 2 edges
        add(1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0);
        // reset priority over a pressed button
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0);
        // held from reset release: first edge enters PULSE
        add(1'b1, 1'b0, 1'b1);
        // reset on the edge that would leave PULSE, then fresh pulse
        add(1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0);
        // short press and minimum 3-cycle spacing
        add(1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < int'(nvec); i++) begin
            step(vecs[i].rst, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Long hold: exactly one pulse over 20 edges.
        pulses = 0;
        step(1'b1, 1'b1, 1'b0, "hold_idle");
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            B_in = 1'b0;
            @(posedge Clk);
            #1;
            if (B_out === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL hold_pulses: count=%0d expected=1", pulses);
        end

        // Alternating input from INIT: INIT->PULSE->WAIT->WAIT->INIT, period 4.
        step(1'b1, 1'b1, 1'b0, "alt_rel");
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b1, $sformatf("alt%0d_a", k));
            step(1'b1, 1'b1, 1'b0, $sformatf("alt%0d_b", k));
            step(1'b1, 1'b0, 1'b0, $sformatf("alt%0d_c", k));
            step(1'b1, 1'b1, 1'b0, $sformatf("alt%0d_d", k));
        end

        // No combinational path: pressing mid-cycle must not move B_out before the edge.
        @(negedge Clk);
        B_in = 1'b0;
        #2;
        check("no_comb_path", B_out, 1'b0);
        @(posedge Clk);
        #1;
        check("after_edge", B_out, 1'b1);

        // Reset held in WAIT aborts the sequence.
        step(1'b1, 1'b0, 1'b0, "wait_pre");
        step(1'b0, 1'b0, 1'b0, "wait_rst");
        step(1'b1, 1'b0, 1'b1, "wait_rst_repress");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
